// File: rtl/exu_operand_stage.sv
// Decode-to-ALU pipeline register: selects ALU operands at accept time and holds them in a
// 2-entry skid buffer so in_ready comes straight from a flop.
module exu_operand_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_src1_sel,
    input  logic [1:0]        in_src2_sel,
    input  logic [CTRL_W-1:0] in_alu_ctrl,
    input  logic [4:0]        in_rd,
    input  logic              in_wen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   opnum1,
    output logic [XLEN-1:0]   opnum2,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_store_data,
    output logic [4:0]        out_rd,
    output logic              out_wen,
    output logic [31:0]       issue_count
);

    typedef enum logic [1:0] {StEmpty, StHold, StFull} state_e;

    state_e state_q, state_d;
    logic   in_ready_q;
    logic   accept, issue;
    logic   load_m_in, load_m_skid, load_s;

    logic [XLEN-1:0] sel_op1, sel_op2;

    logic [XLEN-1:0]   m_op1_q, m_op2_q, m_pc_q, m_sd_q;
    logic [CTRL_W-1:0] m_ctrl_q;
    logic [4:0]        m_rd_q;
    logic              m_wen_q;
    logic [XLEN-1:0]   s_op1_q, s_op2_q, s_pc_q, s_sd_q;
    logic [CTRL_W-1:0] s_ctrl_q;
    logic [4:0]        s_rd_q;
    logic              s_wen_q;
    logic [31:0]       issue_count_q;

    assign out_valid = (state_q != StEmpty);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q;
    assign issue     = out_valid & out_ready;

    always_comb begin
        sel_op1 = in_src1_sel ? in_pc : in_rs1_data;
        unique case (in_src2_sel)
            2'b00:   sel_op2 = in_rs2_data;
            2'b01:   sel_op2 = in_imm;
            2'b10:   sel_op2 = XLEN'(4);
            default: sel_op2 = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d   = StHold;
                    load_m_in = 1'b1;
                end
            end
            StHold: begin
                if (accept && issue) begin
                    load_m_in = 1'b1;
                end else if (accept) begin
                    state_d = StFull;
                    load_s  = 1'b1;
                end else if (issue) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (issue) begin
                    state_d     = StHold;
                    load_m_skid = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Redirect kills everything, including a same-cycle accept
        if (flush) begin
            state_d     = StEmpty;
            load_m_in   = 1'b0;
            load_m_skid = 1'b0;
            load_s      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StEmpty;
            in_ready_q    <= 1'b1;
            issue_count_q <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != StFull);
            if (issue) begin
                issue_count_q <= issue_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_op1_q  <= '0;
            m_op2_q  <= '0;
            m_pc_q   <= '0;
            m_sd_q   <= '0;
            m_ctrl_q <= '0;
            m_rd_q   <= '0;
            m_wen_q  <= 1'b0;
            s_op1_q  <= '0;
            s_op2_q  <= '0;
            s_pc_q   <= '0;
            s_sd_q   <= '0;
            s_ctrl_q <= '0;
            s_rd_q   <= '0;
            s_wen_q  <= 1'b0;
        end else begin
            if (load_m_in) begin
                m_op1_q  <= sel_op1;
                m_op2_q  <= sel_op2;
                m_pc_q   <= in_pc;
                m_sd_q   <= in_rs2_data;
                m_ctrl_q <= in_alu_ctrl;
                m_rd_q   <= in_rd;
                m_wen_q  <= in_wen;
            end else if (load_m_skid) begin
                m_op1_q  <= s_op1_q;
                m_op2_q  <= s_op2_q;
                m_pc_q   <= s_pc_q;
                m_sd_q   <= s_sd_q;
                m_ctrl_q <= s_ctrl_q;
                m_rd_q   <= s_rd_q;
                m_wen_q  <= s_wen_q;
            end
            if (load_s) begin
                s_op1_q  <= sel_op1;
                s_op2_q  <= sel_op2;
                s_pc_q   <= in_pc;
                s_sd_q   <= in_rs2_data;
                s_ctrl_q <= in_alu_ctrl;
                s_rd_q   <= in_rd;
                s_wen_q  <= in_wen;
            end
        end
    end

    assign opnum1         = m_op1_q;
    assign opnum2         = m_op2_q;
    assign alu_ctrl       = m_ctrl_q;
    assign out_pc         = m_pc_q;
    assign out_store_data = m_sd_q;
    assign out_rd         = m_rd_q;
    assign out_wen        = m_wen_q & out_valid;
    assign issue_count    = issue_count_q;

endmodule

// File: doc/exu_operand_stage.md
Name: exu_operand_stage

Overview:
- Pipeline register between the decode stage (IDU) and the ALU in the NPC execute path.
- Accepts decoded instructions over a valid/ready handshake and selects ALU operands (rs1/pc, rs2/imm/4).
- Presents registered opnum1/opnum2/ctrl to the ALU and passes writeback sideband downstream.
- A 2-entry skid buffer keeps in_ready a pure register output, so there is no combinational ready path back to decode.

Parameters:
- XLEN, 32, datapath width of operands, pc and immediate.
- CTRL_W, 2, width of the ALU control field passed through.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all held entries (branch redirect).
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  stage can accept; registered.
- in_pc  input  XLEN  instruction pc.
- in_rs1_data  input  XLEN  register-file rs1 value.
- in_rs2_data  input  XLEN  register-file rs2 value.
- in_imm  input  XLEN  sign-extended immediate.
- in_src1_sel  input  1  0: rs1, 1: pc.
- in_src2_sel  input  2  00: rs2, 01: imm, 10: constant 4, 11: zero.
- in_alu_ctrl  input  CTRL_W  ALU operation code.
- in_rd  input  5  destination register index.
- in_wen  input  1  register writeback enable.
- out_valid  output  1  operands valid for the ALU/writeback consumer.
- out_ready  input  1  downstream consumes this cycle.
- opnum1  output  XLEN  ALU operand 1.
- opnum2  output  XLEN  ALU operand 2.
- alu_ctrl  output  CTRL_W  ALU control.
- out_pc  output  XLEN  pc of the held instruction.
- out_store_data  output  XLEN  raw rs2 value, for the LSU.
- out_rd  output  5  destination index.
- out_wen  output  1  writeback enable, qualified by out_valid.
- issue_count  output  32  number of completed output handshakes.

Behaviour:
- Operand selection is combinational on the input side and captured at accept time. Outputs come straight from the main register.
- Storage: main entry (M) and skid entry (S), each with a valid bit.
- States:
  - EMPTY: M and S invalid.
  - HOLD: M valid, S invalid.
  - FULL: both valid.
- Handshakes: accept = in_valid & in_ready; issue = out_valid & out_ready.
- in_ready = ~S.valid, taken from a register. out_valid = M.valid.
- Transitions when flush = 0:
  - EMPTY, accept → HOLD; M captures the input.
  - HOLD, accept and issue → HOLD; M captures the new input.
  - HOLD, accept without issue → FULL; S captures the input, M is unchanged.
  - HOLD, issue without accept → EMPTY.
  - FULL, issue → HOLD; M takes S. Accept is impossible in FULL because in_ready = 0.
  - Any other combination → no change.
- Latency: an instruction accepted in cycle N is on the outputs in cycle N+1.
- Ordering is strict FIFO. No bubble when accept and issue happen together in HOLD, so sustained throughput is 1 per cycle.
- flush = 1: at the next edge M.valid = 0, S.valid = 0 and in_ready = 1. A same-cycle accept is discarded. A same-cycle issue still counts, because the consumer already took it.
- Datapath registers update only on capture. When an entry is invalid its contents are don't-care, but out_wen is forced to 0 whenever out_valid = 0.
- issue_count increments by 1 on each issue, wraps modulo 2^32, and is not cleared by flush.
- Reset (asserts asynchronously, deasserts on clk):
  - out_valid = 0, in_ready = 1, issue_count = 0.
  - opnum1, opnum2, out_pc, out_store_data = 0.
  - alu_ctrl = 0, out_rd = 0, out_wen = 0.
  - Reset in the middle of FULL drops both entries.
- Inputs must be held stable by decode while in_valid = 1 and in_ready = 0. The block does not check this.

Test Plan:
- Single op: in_src1_sel=0, in_src2_sel=01, rs1=0x10, imm=0xFFFFFFFC, out_ready=1 → next cycle out_valid=1, opnum1=0x10, opnum2=0xFFFFFFFC, then out_valid=0; issue_count=1.
- Back-to-back stream: 8 ops with in_valid and out_ready held high → one output per cycle, in order, in_ready always 1, issue_count=8.
- Backpressure: out_ready=0, send ops A and B → in_ready=0 after B, out shows A. Raise out_ready → A, then B, then empty; in_ready returns to 1 the cycle after A issues.
- Operand muxing: in_src1_sel=1, pc=0x80000004, in_src2_sel=10 → opnum1=0x80000004, opnum2=4. With in_src2_sel=11 → opnum2=0. out_store_data always equals rs2.
- Flush in FULL with a simultaneous issue → next cycle out_valid=0, in_ready=1, issue_count incremented once, neither entry reappears.
- Async reset asserted mid-cycle in FULL → outputs clear immediately without a clock edge; after release, the first accepted op appears with 1-cycle latency.
